// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and queued load returns into the single
// register-file write port, and tracks registers still waiting on a load.
module wb_arbiter #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_rd,
  input  logic [4:0]  i_q_rd1,
  input  logic [4:0]  i_q_rd2,
  output logic        o_busy1,
  output logic        o_busy2,
  output logic        o_w_en,
  output logic [4:0]  o_w_indx,
  output logic [31:0] o_w_data
);

  localparam int PW = $clog2(LQ_DEPTH);

  typedef enum logic {
    TAG_ALU  = 1'b0,
    TAG_LOAD = 1'b1
  } tag_t;

  logic [4:0]  r_lq_rd   [LQ_DEPTH];
  logic [31:0] r_lq_data [LQ_DEPTH];
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  logic [31:0] r_pending;
  tag_t        r_tag;
  logic        r_w_en;
  logic [4:0]  r_w_indx;
  logic [31:0] r_w_data;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_alu;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_data;
  logic [31:0] w_pending_nxt;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_ld_ready  = !w_full && !i_rst;
  assign w_push      = i_ld_valid && o_ld_ready;
  assign w_alu       = i_alu_valid && (i_alu_rd != 5'd0);
  assign w_pop       = !w_alu && !w_empty;
  assign w_head_rd   = r_lq_rd[r_rptr[PW-1:0]];
  assign w_head_data = r_lq_data[r_rptr[PW-1:0]];

  assign o_w_en   = r_w_en;
  assign o_w_indx = r_w_indx;
  assign o_w_data = r_w_data;
  assign o_busy1  = r_pending[i_q_rd1];
  assign o_busy2  = r_pending[i_q_rd2];

  // A new issue to a register wins over a load write clearing it at the same edge.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_w_en && (r_tag == TAG_LOAD)) begin
      w_pending_nxt[r_w_indx] = 1'b0;
    end
    if (i_iss_valid) begin
      w_pending_nxt[i_iss_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_lq_rd[r_wptr[PW-1:0]]   <= i_ld_rd;
      r_lq_data[r_wptr[PW-1:0]] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pending <= '0;
      r_tag     <= TAG_ALU;
      r_w_en    <= 1'b0;
      r_w_indx  <= 5'd0;
      r_w_data  <= 32'd0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + {{PW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{PW{1'b0}}, 1'b1};
      end
      if (w_alu) begin
        r_w_en   <= 1'b1;
        r_w_indx <= i_alu_rd;
        r_w_data <= i_alu_data;
        r_tag    <= TAG_ALU;
      end else if (w_pop && (w_head_rd != 5'd0)) begin
        r_w_en   <= 1'b1;
        r_w_indx <= w_head_rd;
        r_w_data <= w_head_data;
        r_tag    <= TAG_LOAD;
      end else begin
        // Idle or an x0 load being discarded: index and data keep their last values.
        r_w_en <= 1'b0;
        r_tag  <= TAG_ALU;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_wb_arbiter;

  localparam int LQ_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        ldValid;
  logic        ldReady;
  logic [4:0]  ldRd;
  logic [31:0] ldData;
  logic        issValid;
  logic [4:0]  issRd;
  logic [4:0]  qRd1;
  logic [4:0]  qRd2;
  logic        busy1;
  logic        busy2;
  logic        wEn;
  logic [4:0]  wIndx;
  logic [31:0] wData;

  int vectorsApplied = 0;
  int miscompares    = 0;

  wb_arbiter #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_alu_valid (aluValid),
    .i_alu_rd    (aluRd),
    .i_alu_data  (aluData),
    .i_ld_valid  (ldValid),
    .o_ld_ready  (ldReady),
    .i_ld_rd     (ldRd),
    .i_ld_data   (ldData),
    .i_iss_valid (issValid),
    .i_iss_rd    (issRd),
    .i_q_rd1     (qRd1),
    .i_q_rd2     (qRd2),
    .o_busy1     (busy1),
    .o_busy2     (busy2),
    .o_w_en      (wEn),
    .o_w_indx    (wIndx),
    .o_w_data    (wData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        ldValid;
    logic [4:0]  ldRd;
    logic [31:0] ldData;
    logic        issValid;
    logic [4:0]  issRd;
    logic [4:0]  q1;
    logic [4:0]  q2;
  } stim_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  // Reference model state: what the register-file port and scoreboard must show.
  entry_t      mQ[$];
  entry_t      mHead;
  logic [31:0] mPend;
  logic        mEn;
  logic [4:0]  mIndx;
  logic [31:0] mData;
  logic        mLastWasLoad;
  logic        mRoom;
  logic        checkEn = 1'b0;

  function automatic stim_t idle(input logic [4:0] q1, input logic [4:0] q2);
    stim_t s;
    s    = '0;
    s.q1 = q1;
    s.q2 = q2;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #2;
    rst      = s.rst;
    aluValid = s.aluValid;
    aluRd    = s.aluRd;
    aluData  = s.aluData;
    ldValid  = s.ldValid;
    ldRd     = s.ldRd;
    ldData   = s.ldData;
    issValid = s.issValid;
    issRd    = s.issRd;
    qRd1     = s.q1;
    qRd2     = s.q2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each edge from the inputs held stable across that edge.
  always @(posedge clk) begin
    if (rst) begin
      mQ.delete();
      mPend        = '0;
      mEn          = 1'b0;
      mIndx        = 5'd0;
      mData        = 32'd0;
      mLastWasLoad = 1'b0;
      checkEn      = 1'b1;
    end else if (checkEn) begin
      if (mEn && mLastWasLoad) mPend[mIndx] = 1'b0;
      if (issValid && issRd != 5'd0) mPend[issRd] = 1'b1;
      mRoom = (mQ.size() < LQ_DEPTH);
      if (aluValid && aluRd != 5'd0) begin
        mEn          = 1'b1;
        mIndx        = aluRd;
        mData        = aluData;
        mLastWasLoad = 1'b0;
      end else if (mQ.size() > 0) begin
        mHead = mQ.pop_front();
        if (mHead.rd != 5'd0) begin
          mEn          = 1'b1;
          mIndx        = mHead.rd;
          mData        = mHead.data;
          mLastWasLoad = 1'b1;
        end else begin
          mEn          = 1'b0;
          mLastWasLoad = 1'b0;
        end
      end else begin
        mEn          = 1'b0;
        mLastWasLoad = 1'b0;
      end
      if (ldValid && mRoom) mQ.push_back({ldRd, ldData});
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_w_en",     {31'd0, wEn}, {31'd0, mEn});
      checkOutput("model_w_indx",   {27'd0, wIndx}, {27'd0, mIndx});
      checkOutput("model_w_data",   wData, mData);
      checkOutput("model_ld_ready", {31'd0, ldReady}, {31'd0, (!rst && mQ.size() < LQ_DEPTH)});
      checkOutput("model_busy1",    {31'd0, busy1}, {31'd0, mPend[qRd1]});
      checkOutput("model_busy2",    {31'd0, busy2}, {31'd0, mPend[qRd2]});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    rst = 1'b1; aluValid = 1'b0; aluRd = '0; aluData = '0;
    ldValid = 1'b0; ldRd = '0; ldData = '0; issValid = 1'b0; issRd = '0;
    qRd1 = '0; qRd2 = '0;

    // Reset, then the first idle cycle
    s = idle(5'd0, 5'd0); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    #1 checkOutput("ld_ready_in_reset", {31'd0, ldReady}, 32'd0);
    applyStimulus(idle(5'd0, 5'd0));
    #1;
    checkOutput("reset_w_en",     {31'd0, wEn}, 32'd0);
    checkOutput("reset_w_indx",   {27'd0, wIndx}, 32'd0);
    checkOutput("reset_w_data",   wData, 32'd0);
    checkOutput("reset_ld_ready", {31'd0, ldReady}, 32'd1);
    checkOutput("reset_busy1",    {31'd0, busy1}, 32'd0);
    checkOutput("reset_busy2",    {31'd0, busy2}, 32'd0);

    // Single ALU write
    s = idle(5'd0, 5'd0); s.aluValid = 1'b1; s.aluRd = 5'd5; s.aluData = 32'h1234;
    applyStimulus(s);
    applyStimulus(idle(5'd0, 5'd0));
    #1;
    checkOutput("alu_w_en",   {31'd0, wEn}, 32'd1);
    checkOutput("alu_w_indx", {27'd0, wIndx}, 32'd5);
    checkOutput("alu_w_data", wData, 32'h1234);
    applyStimulus(idle(5'd0, 5'd0));
    #1 checkOutput("alu_w_en_after", {31'd0, wEn}, 32'd0);

    // Issue load to x7, return it, watch busy1
    s = idle(5'd7, 5'd0); s.issValid = 1'b1; s.issRd = 5'd7;
    applyStimulus(s);
    s = idle(5'd7, 5'd0); s.ldValid = 1'b1; s.ldRd = 5'd7; s.ldData = 32'hDEADBEEF;
    applyStimulus(s);
    #1 checkOutput("ld7_busy_accept", {31'd0, busy1}, 32'd1);
    applyStimulus(idle(5'd7, 5'd0));
    #1 checkOutput("ld7_busy_wait", {31'd0, busy1}, 32'd1);
    checkOutput("ld7_w_en_wait", {31'd0, wEn}, 32'd0);
    applyStimulus(idle(5'd7, 5'd0));
    #1;
    checkOutput("ld7_w_en",   {31'd0, wEn}, 32'd1);
    checkOutput("ld7_w_indx", {27'd0, wIndx}, 32'd7);
    checkOutput("ld7_w_data", wData, 32'hDEADBEEF);
    checkOutput("ld7_busy_write", {31'd0, busy1}, 32'd1);
    applyStimulus(idle(5'd7, 5'd0));
    #1 checkOutput("ld7_busy_after", {31'd0, busy1}, 32'd0);

    // Two loads queued behind three ALU writes; third load offered while full
    s = idle(5'd0, 5'd0); s.aluValid = 1'b1; s.aluRd = 5'd9; s.aluData = 32'h900;
    s.ldValid = 1'b1; s.ldRd = 5'd3; s.ldData = 32'h333;
    applyStimulus(s);
    s.aluData = 32'h901; s.ldRd = 5'd4; s.ldData = 32'h444;
    applyStimulus(s);
    #1 checkOutput("q_ready_one", {31'd0, ldReady}, 32'd1);
    s.aluData = 32'h902; s.ldRd = 5'd11; s.ldData = 32'hBAD;
    applyStimulus(s);
    #1;
    checkOutput("q_ready_full", {31'd0, ldReady}, 32'd0);
    checkOutput("q_alu2_indx",  {27'd0, wIndx}, 32'd9);
    checkOutput("q_alu2_data",  wData, 32'h901);
    applyStimulus(idle(5'd0, 5'd0));
    #1 checkOutput("q_alu3_data", wData, 32'h902);
    applyStimulus(idle(5'd0, 5'd0));
    #1;
    checkOutput("q_ld3_w_en", {31'd0, wEn}, 32'd1);
    checkOutput("q_ld3_indx", {27'd0, wIndx}, 32'd3);
    checkOutput("q_ld3_data", wData, 32'h333);
    applyStimulus(idle(5'd0, 5'd0));
    #1;
    checkOutput("q_ld4_indx", {27'd0, wIndx}, 32'd4);
    checkOutput("q_ld4_data", wData, 32'h444);
    applyStimulus(idle(5'd0, 5'd0));
    #1 checkOutput("q_no_ld11", {31'd0, wEn}, 32'd0);

    // ALU to x0 does not block a load; a load to x0 is popped silently
    s = idle(5'd0, 5'd0); s.ldValid = 1'b1; s.ldRd = 5'd2; s.ldData = 32'h22;
    applyStimulus(s);
    s = idle(5'd0, 5'd0); s.aluValid = 1'b1; s.aluRd = 5'd0; s.aluData = 32'hFFFF;
    applyStimulus(s);
    applyStimulus(idle(5'd0, 5'd0));
    #1;
    checkOutput("x0alu_ld2_w_en", {31'd0, wEn}, 32'd1);
    checkOutput("x0alu_ld2_indx", {27'd0, wIndx}, 32'd2);
    s = idle(5'd0, 5'd0); s.ldValid = 1'b1; s.ldRd = 5'd0; s.ldData = 32'h55;
    applyStimulus(s);
    applyStimulus(idle(5'd0, 5'd0));
    applyStimulus(idle(5'd0, 5'd0));
    #1;
    checkOutput("x0ld_w_en", {31'd0, wEn}, 32'd0);
    checkOutput("x0ld_hold_indx", {27'd0, wIndx}, 32'd2);
    checkOutput("x0ld_hold_data", wData, 32'h22);

    // Re-issue to x6 at the same edge its load write clears: set wins
    s = idle(5'd6, 5'd0); s.issValid = 1'b1; s.issRd = 5'd6;
    applyStimulus(s);
    s = idle(5'd6, 5'd0); s.ldValid = 1'b1; s.ldRd = 5'd6; s.ldData = 32'h66;
    applyStimulus(s);
    applyStimulus(idle(5'd6, 5'd0));
    s = idle(5'd6, 5'd0); s.issValid = 1'b1; s.issRd = 5'd6;
    applyStimulus(s);
    #1 checkOutput("setwin_w_indx", {27'd0, wIndx}, 32'd6);
    s = idle(5'd6, 5'd0); s.ldValid = 1'b1; s.ldRd = 5'd6; s.ldData = 32'h67;
    applyStimulus(s);
    #1 checkOutput("setwin_busy", {31'd0, busy1}, 32'd1);
    applyStimulus(idle(5'd6, 5'd0));
    applyStimulus(idle(5'd6, 5'd0));
    #1 checkOutput("setwin_ld67_data", wData, 32'h67);
    applyStimulus(idle(5'd6, 5'd0));
    #1 checkOutput("setwin_busy_clear", {31'd0, busy1}, 32'd0);

    // Reset with two loads queued and one pending register
    s = idle(5'd0, 5'd12); s.aluValid = 1'b1; s.aluRd = 5'd13; s.aluData = 32'hD00;
    s.ldValid = 1'b1; s.ldRd = 5'd12; s.ldData = 32'hC0C; s.issValid = 1'b1; s.issRd = 5'd12;
    applyStimulus(s);
    s.issValid = 1'b0; s.ldRd = 5'd14; s.ldData = 32'hE0E;
    applyStimulus(s);
    #1 checkOutput("rst_busy2_before", {31'd0, busy2}, 32'd1);
    s = idle(5'd0, 5'd12); s.rst = 1'b1;
    applyStimulus(s);
    #1 checkOutput("rst_ld_ready_low", {31'd0, ldReady}, 32'd0);
    applyStimulus(idle(5'd0, 5'd12));
    #1;
    checkOutput("rst_mid_w_en",     {31'd0, wEn}, 32'd0);
    checkOutput("rst_mid_ld_ready", {31'd0, ldReady}, 32'd1);
    checkOutput("rst_mid_busy2",    {31'd0, busy2}, 32'd0);
    applyStimulus(idle(5'd0, 5'd12));
    #1 checkOutput("rst_mid_no_write", {31'd0, wEn}, 32'd0);
    applyStimulus(idle(5'd0, 5'd0));
    applyStimulus(idle(5'd0, 5'd0));
    @(posedge clk);
    #6;

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that owns the single write port of the core's register file. It merges single-cycle ALU results with multi-cycle load returns into one registered write stream (`w_en`/`w_indx`/`w_data`), buffering loads in a small queue. It keeps a per-register pending-load scoreboard that decode queries to stall operand reads until the load data has actually been written.

## Interface
- `LQ_DEPTH`, default 2: load-return queue entries; power of 2, ≥2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no backpressure.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `ld_valid`  in  1  load return present.
- `ld_ready`  out  1  queue can accept; transfer when `ld_valid && ld_ready`.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load data.
- `iss_valid`  in  1  a load is issued this cycle.
- `iss_rd`  in  5  destination of issued load.
- `q_rd1`, `q_rd2`  in  5 each  decode source-register queries.
- `busy1`, `busy2`  out  1 each  queried register has a pending load; combinational.
- `w_en`  out  1  register-file write enable; registered.
- `w_indx`  out  5  register-file write index; registered.
- `w_data`  out  32  register-file write data; registered.

## Operation
- Load queue: circular FIFO of {rd, data}, `LQ_DEPTH` entries, read/write pointers with an extra wrap bit.
- `ld_ready` = queue not full, derived from registered state only. No pass-through when full.
- Arbitration, once per cycle, into the output register:
  - ALU has priority if `alu_valid && alu_rd != 0`. The output is loaded with ALU rd/data, tag = ALU.
  - Otherwise, if the queue is non-empty, pop the head. If head rd != 0, the output is loaded with head rd/data, tag = LOAD.
  - A head with rd == 0 is popped with `w_en` = 0 next cycle. It consumes the slot and does nothing else.
  - Otherwise `w_en` goes to 0. `w_indx` and `w_data` hold their last values.
- An ALU write to x0 is dropped and does not block a load pop in the same cycle.
- Push and pop in the same cycle are allowed, including when the queue is full: pop frees the slot, but `ld_ready` was already 0, so no push occurs.
- Scoreboard: 32 pending bits; bit 0 is always 0.
  - Set at the edge where `iss_valid && iss_rd != 0`.
  - Cleared at the edge ending a cycle in which `w_en` = 1 with tag LOAD, for `w_indx`. This is the same edge the register file stores the data.
  - If a set and a clear hit the same register at the same edge, set wins.
- `busyN` = pending[`q_rdN`]. It is 0 for x0.
- Decode must not issue a second load to a pending register. If it does, the bit is simply re-set and the first return clears it; the bench does not check beyond that.
- An ALU write to a pending rd commits normally. The pending bit is unaffected, and the later load overwrites.

## Timing
- Reset values: `w_en` = 0, `w_indx` = 0, `w_data` = 0, tag = ALU, queue empty (pointers 0). All pending bits are 0, so `busy1`/`busy2` = 0. `ld_ready` is 0 while `rst` is high and 1 in the first cycle after.
- Reset mid-operation discards queued loads and pending bits. There is no write on the cycle after reset.
- ALU latency: `alu_valid` in cycle N gives `w_en` = 1 in cycle N+1, and the data is in the register file from cycle N+2.
- Load latency:
  - Minimum: accepted in cycle N, output in N+2.
  - Each ALU write arriving during the wait delays it by one cycle.
- Throughput: one register-file write per cycle.
- A queued load can starve under back-to-back ALU traffic. Upstream guarantees gaps.
- Busy timing: `busy` stays 1 through the cycle where `w_en` carries the load write. It is 0 from the following cycle, when the asynchronous register-file read already returns the new data.

## Test plan
- Reset then idle → `w_en`=0, `w_indx`=0, `w_data`=0, `ld_ready`=1, `busy1`=`busy2`=0.
- `alu_valid`=1, rd=5, data=0x1234 at cycle N → cycle N+1: `w_en`=1, `w_indx`=5, `w_data`=0x1234. Cycle N+2: `w_en`=0.
- `iss_rd`=7, then load return rd=7, data=0xDEADBEEF with `q_rd1`=7 → `busy1`=1 until the cycle `w_en`=1/`w_indx`=7 inclusive, and 0 in the next cycle.
- Two loads (rd=3, rd=4) pushed back-to-back while `alu_valid`=1 (rd=9) for 3 cycles:
  - → `ld_ready`=0 after the 2nd push.
  - → the ALU wins all three slots.
  - → rd 3 then rd 4 are written in the next two cycles, in order.
- ALU rd=0 with a queued load rd=2 → the load is written the next cycle. A load with rd=0 is popped with `w_en`=0.
- `iss_rd`=6 at the same edge a LOAD write to 6 clears → `busy` stays 1. Assert `rst` with 2 queued loads → the queue is empty and no write follows.
